// File: rtl/display_pkg.sv
// Shared types, segment encodings and helpers for the result display.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Non-BCD nibbles cannot occur after a valid conversion; show them blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to each nibble before the shift.
  function automatic logic [3:0] dabble(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for load; captures magnitude and sign on load
//  CONVERT | one double-dabble iteration per cycle, WIDTH iterations
//  DONE    | publishes shadow to bcd/negative, pulses done next cycle
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              is_signed,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd,
  output logic              negative
);

  localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mag_q;
  logic [4*NDIG-1:0]   shadow_q;
  logic [ITER_W-1:0]   iter_q;
  logic                neg_q;
  logic [4*NDIG-1:0]   shadow_adj;
  logic [4*NDIG-1:0]   shadow_next;
  logic [WIDTH-1:0]    mag_next;

  // Next-state decode and busy flag.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: begin
        busy = 1'b1;
        if (iter_q == ITER_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {shadow, mag} left.
  always_comb begin
    shadow_adj = '0;
    for (int i = 0; i < NDIG; i++) begin
      shadow_adj[4*i +: 4] = dabble(shadow_q[4*i +: 4]);
    end
    shadow_next = {shadow_adj[4*NDIG-2:0], mag_q[WIDTH-1]};
    mag_next    = {mag_q[WIDTH-2:0], 1'b0};
  end

  // State register and conversion datapath; bcd/negative only change in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      shadow_q <= '0;
      iter_q   <= '0;
      neg_q    <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            if (is_signed && data_in[WIDTH-1]) begin
              mag_q <= ~data_in + WIDTH'(1);
              neg_q <= 1'b1;
            end else begin
              mag_q <= data_in;
              neg_q <= 1'b0;
            end
            shadow_q <= '0;
            iter_q   <= '0;
          end
        end
        CONVERT: begin
          shadow_q <= shadow_next;
          mag_q    <= mag_next;
          iter_q   <= iter_q + ITER_W'(1);
        end
        DONE: begin
          bcd      <= shadow_q;
          negative <= neg_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// Converts a binary result to BCD and scans it onto a multiplexed 7-segment
// display with a sign position and leading-zero blanking.
module result_display
  import display_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NDIG     = 5,
  parameter int SCAN_DIV = 27000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              is_signed,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd,
  output logic              negative,
  output logic [NDIG:0]     anodes,
  output logic [6:0]        segments
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int POS_W  = $clog2(NDIG + 1);

  logic [SCAN_W-1:0] scan_q;
  logic [POS_W-1:0]  pos_q;
  logic [NDIG:0]     zero_from;
  logic [NDIG:0]     an_d;
  logic [6:0]        seg_d;

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .NDIG  (NDIG)
  ) u_conv (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .is_signed (is_signed),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .negative  (negative)
  );

  // Dwell counter; each wrap advances the lit position, sign position last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q <= '0;
      pos_q  <= '0;
    end else if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      pos_q  <= (pos_q == POS_W'(NDIG)) ? '0 : pos_q + POS_W'(1);
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
    end
  end

  // zero_from[i] is set when digit i and every digit above it are zero.
  always_comb begin
    zero_from       = '0;
    zero_from[NDIG] = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (bcd[4*i +: 4] == 4'd0);
    end
  end

  // Anode enable and segment source for the current position.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    for (int i = 0; i <= NDIG; i++) begin
      an_d[i] = (pos_q != POS_W'(i));
    end
    if (pos_q == POS_W'(NDIG)) begin
      seg_d = negative ? SEG_MINUS : SEG_BLANK;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (pos_q == POS_W'(i) && (i == 0 || !zero_from[i])) begin
          seg_d = seg_decode(bcd[4*i +: 4]);
        end
      end
    end
  end

  // Registered drivers keep the pad outputs glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anodes   <= {{NDIG{1'b1}}, 1'b0};
      segments <= SEG_0;
    end else begin
      anodes   <= an_d;
      segments <= seg_d;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed cases from the test plan
// plus random values, compared against a decimal-arithmetic reference model.
module tb_result_display;

  localparam int WIDTH    = 16;
  localparam int NDIG     = 5;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  data_in = '0;
  logic              is_signed = 1'b0;
  logic              load = 1'b0;
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] bcd;
  logic              negative;
  logic [NDIG:0]     anodes;
  logic [6:0]        segments;

  int n_checks = 0;
  int n_errors = 0;

  logic [4*NDIG-1:0] prev_bcd = '0;
  logic              prev_neg = 1'b0;
  int                prev_val = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  result_display #(
    .WIDTH    (WIDTH),
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .is_signed (is_signed),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .negative  (negative),
    .anodes    (anodes),
    .segments  (segments)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_mag(input logic [WIDTH-1:0] d, input logic s);
    if (s && d[WIDTH-1]) return 65536 - int'(d);
    return int'(d);
  endfunction

  function automatic logic [4*NDIG-1:0] ref_bcd(input int m);
    logic [4*NDIG-1:0] r;
    int pw;
    r  = '0;
    pw = 1;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'((m / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int p, input int v, input logic neg);
    int pw;
    if (p == NDIG) return neg ? 7'b0111111 : 7'b1111111;
    pw = 1;
    for (int i = 0; i < p; i++) pw = pw * 10;
    if (p > 0 && (v / pw) == 0) return 7'b1111111;
    return seg_tab[(v / pw) % 10];
  endfunction

  // Load a value, wait for done within a cycle budget, optionally fire a
  // second load mid-conversion, and check latency, hold, result and pulse.
  task automatic run_conv(input logic [WIDTH-1:0] d, input logic s,
                          input int inj_cycle, input string tag);
    int  k;
    bit  got;
    bit  held;
    int  extra;
    int  m;
    @(negedge clk);
    data_in   = d;
    is_signed = s;
    load      = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    k    = 0;
    got  = 1'b0;
    held = 1'b1;
    while (k < 40 && !got) begin
      if (inj_cycle != 0 && k == inj_cycle) begin
        data_in = 16'd999;
        load    = 1'b1;
      end
      @(posedge clk);
      k++;
      #1;
      load = 1'b0;
      if (done) got = 1'b1;
      else if (bcd !== prev_bcd || negative !== prev_neg) held = 1'b0;
    end
    check({tag, "_latency"}, 32'(k), 32'd17);
    check({tag, "_hold"}, 32'(held), 32'd1);
    m = ref_mag(d, s);
    check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(m)));
    check({tag, "_neg"}, 32'(negative), 32'(s && d[WIDTH-1]));
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check({tag, "_single_done"}, 32'(extra), 32'd0);
    prev_bcd = ref_bcd(m);
    prev_neg = s && d[WIDTH-1];
    prev_val = m;
  endtask

  // Watch the scan for a while: one anode low, positions advance in order
  // with SCAN_DIV cycles each, segments match the model for that position.
  task automatic check_display(input string tag);
    int  p;
    int  lastp;
    int  run;
    bit  seen_trans;
    lastp      = -1;
    run        = 0;
    seen_trans = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      check({tag, "_onehot"}, 32'($countones(~anodes)), 32'd1);
      p = 0;
      for (int i = 0; i <= NDIG; i++) if (!anodes[i]) p = i;
      check({tag, "_seg"}, 32'(segments), 32'(ref_seg(p, prev_val, prev_neg)));
      if (p == lastp) begin
        run++;
      end else begin
        if (lastp >= 0) begin
          check({tag, "_step"}, 32'(p), 32'((lastp + 1) % (NDIG + 1)));
          if (seen_trans) check({tag, "_dwell"}, 32'(run), 32'(SCAN_DIV));
          seen_trans = 1'b1;
        end
        lastp = p;
        run   = 1;
      end
    end
  endtask

  initial begin
    int extra;
    logic [WIDTH-1:0] rv;
    logic             rs;

    #2 rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_neg", 32'(negative), 32'd0);
    check("rst_anodes", 32'(anodes), 32'b111110);
    check("rst_segments", 32'(segments), 32'b1000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_conv(16'h0000, 1'b1, 0, "zero");
    check_display("zero_disp");
    run_conv(16'hFFFF, 1'b1, 0, "minus_one");
    check_display("minus_one_disp");
    run_conv(16'h8000, 1'b1, 0, "most_neg");
    run_conv(16'hC080, 1'b1, 0, "neg_16256");
    check_display("neg_16256_disp");
    run_conv(16'hFFFF, 1'b0, 0, "umax");
    check_display("umax_disp");
    run_conv(16'd123, 1'b0, 5, "busy_prot");
    check_display("scan_123");

    // Reset partway through a conversion.
    @(negedge clk);
    data_in   = 16'd777;
    is_signed = 1'b0;
    load      = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_neg", 32'(negative), 32'd0);
    prev_bcd = '0;
    prev_neg = 1'b0;
    prev_val = 0;
    @(negedge clk);
    rst   = 1'b1;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("midrst_no_done", 32'(extra), 32'd0);
    run_conv(16'd42, 1'b0, 0, "after_rst");
    check_display("after_rst_disp");

    for (int n = 0; n < 20; n++) begin
      rv = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_conv(rv, rs, 0, "rand");
      if (n % 4 == 0) check_display("rand_disp");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
Back end of the calculator datapath. Takes a binary operand or result (signed product from the Booth multiplier, or unsigned keypad value) and runs a sequential double-dabble conversion to decimal BCD. It then drives a time-multiplexed 7-segment display with a sign position and leading-zero blanking. It is the display-side counterpart to the keypad digit accumulator, which converts decimal entry to binary.

Parameters:
WIDTH, 16, width of binary input data_in
NDIG, 5, number of decimal digit positions; NDIG*4 must hold 2^WIDTH-1
SCAN_DIV, 27000, clk cycles each display position stays lit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
data_in  in  WIDTH  binary value to convert
is_signed  in  1  1: treat data_in as two's complement; 0: unsigned
load  in  1  start-conversion strobe, sampled in IDLE only
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when bcd/negative are updated
bcd  out  4*NDIG  packed BCD result, digit 0 = bits [3:0]
negative  out  1  sign of last converted value
anodes  out  NDIG+1  active-low position enables; bit NDIG = sign position
segments  out  7  active-low {g,f,e,d,c,b,a}

Behaviour:
- Reset (rst low, async): FSM=IDLE, busy=0, done=0, bcd=0, negative=0, scan counter=0, position index=0, anodes=all 1 except bit0=0, segments=digit "0" (7'b1000000).
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - On load=1, capture the magnitude: if is_signed and data_in[WIDTH-1]=1, mag = (~data_in+1) as WIDTH-bit unsigned, neg_next=1; else mag = data_in, neg_next=0.
  - Most-negative input (0x8000) yields mag=32768; no overflow.
  - Clear the working BCD shadow, set iteration count=0, assert busy, go to CONVERT.
- CONVERT, one iteration per cycle, WIDTH iterations:
  - Each shadow nibble >=5 gets +3.
  - Then shift {shadow, mag} left by 1.
  - After iteration WIDTH-1, go to DONE.
- DONE (one cycle): bcd<=shadow, negative<=neg_next, done=1, busy=0, next state IDLE.
- Latency: load sampled at edge N; done high in cycle N+WIDTH+1.
- bcd and negative hold their previous values for the whole conversion; they never show partial results.
- load while busy or in DONE: ignored, not queued.
- Async reset mid-conversion: aborts immediately to reset values; no done pulse.
- Scan:
  - Free-running counter 0..SCAN_DIV-1. On wrap, position index advances 0,1,..,NDIG,0.
  - Exactly one anode bit is low at any time.
- Segment source per position:
  - Positions 0..NDIG-1: 7-seg decode of bcd digit. Blank (7'b1111111) if the digit and all higher digits are 0 and the position is >0; digit 0 is always shown.
  - Position NDIG: minus 7'b0111111 if negative, else blank.
  - Non-BCD nibble (>9, not reachable): blank.
- Display reflects bcd/negative registers only; it updates the cycle after done.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, CONVERT, DONE}
  - 7-seg decode constants SEG_0..SEG_9
  - SEG_BLANK, SEG_MINUS
- Sub-module bin2bcd_seq: the FSM + double-dabble, with the load/busy/done/bcd/negative ports above.
- result_display instantiates bin2bcd_seq and adds the scan counter, blanking logic and segment mux.

Test Plan:
- Zero: load data_in=0x0000, is_signed=1.
  - done exactly 17 cycles after load edge; bcd=0x00000, negative=0.
  - Only position 0 shows 7'b1000000; positions 1..5 blank.
- Signed negatives:
  - data_in=0xFFFF, is_signed=1 -> bcd=0x00001, negative=1, position 5 shows 7'b0111111.
  - data_in=0x8000, is_signed=1 -> bcd=0x32768, negative=1.
  - data_in=0xC080 (-16256) -> bcd=0x16256, negative=1.
- Unsigned max: data_in=0xFFFF, is_signed=0 -> bcd=0x65535, negative=0, no blanking.
- Busy protection:
  - Load 123; pulse load with 999 at cycle 5 of CONVERT -> single done, bcd=0x00123.
  - Prior bcd value stable until done.
- Reset mid-operation:
  - rst low during cycle 8 of CONVERT -> busy=0, done=0, bcd=0 immediately, no done pulse.
  - Next load of 42 -> bcd=0x00042.
- Scan with SCAN_DIV=4, value 123 unsigned:
  - anodes step 111110,111101,111011,110111,101111,011111, 4 cycles each.
  - segments: 3=7'b0110000, 2=7'b0100100, 1=7'b1111001, then blank, blank, blank (sign position).
